// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
// The optional statistics counters are enabled by defining CHAN_ERR_STATS_EN.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_RANDOM   = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_PERIODIC = 2'b11
  } err_mode_e;

  typedef enum logic {
    ST_CLEAN = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/chan_err_injector_if.sv
// Symbol stream and status bundle of the channel error injector.
// Handshake: valid-only stream, no backpressure. A symbol is transferred on
// every clk edge where in_valid_i is high; out_valid_o marks the corrupted
// symbol one cycle later. There is no ready signal, the sink must always accept.
interface chan_err_injector_if #(
  parameter int SYM_W = 2
);
  chan_err_pkg::err_mode_e    mode_i;
  logic                       start_i;
  logic                       in_valid_i;
  logic [SYM_W-1:0]           in_sym_i;
  logic                       out_valid_o;
  logic [SYM_W-1:0]           out_sym_o;
  logic [SYM_W-1:0]           err_mask_o;
  logic                       win_active_o;
  logic [15:0]                inj_count_o;
  logic [15:0]                bit_err_count_o;
  chan_err_pkg::burst_state_e dbg_state_o;

  modport master (
    output mode_i, start_i, in_valid_i, in_sym_i,
    input  out_valid_o, out_sym_o, err_mask_o, win_active_o,
    input  inj_count_o, bit_err_count_o, dbg_state_o
  );

  modport slave (
    input  mode_i, start_i, in_valid_i, in_sym_i,
    output out_valid_o, out_sym_o, err_mask_o, win_active_o,
    output inj_count_o, bit_err_count_o, dbg_state_o
  );
endinterface

// File: rtl/chan_lfsr.sv
// 16-bit Galois LFSR that advances one step whenever step is high.
module chan_lfsr
  import chan_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      state <= seed;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/chan_err_injector.sv
// Channel error injector: XORs a mode-dependent error mask onto a symbol stream.
// Define CHAN_ERR_STATS_EN to build the injection and bit-error counters.
module chan_err_injector
  import chan_err_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          RATE_N    = 4,
  parameter int          BURST_LEN = 16,
  parameter int          PERIOD    = 16,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  chan_err_injector_if.slave  bus
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? ZERO_SEED_SUB : SEED;
  localparam logic [15:0] WIN      = 16'(WINDOW);
  localparam logic [7:0]  PER_LAST = 8'(PERIOD - 1);
  localparam logic [7:0]  BL_LAST  = 8'(BURST_LEN - 1);

  logic             accept;
  logic             start;
  err_mode_e        mode;
  logic [15:0]      lfsr_q;
  logic [15:0]      sym_ct_q, eff_ct, ct_next;
  logic [7:0]       per_q, eff_per, per_next;
  logic             eff_active;
  logic             trig;
  logic [SYM_W-1:0] rand_raw, rand_mask, mask_d;
  burst_state_e     state_q, state_d, cur_state;
  logic [7:0]       burst_ct_q, burst_ct_d, cur_burst_ct;
  logic             burst_hit;
  logic             out_valid_q;
  logic [SYM_W-1:0] out_sym_q, err_mask_q;

  assign accept = bus.in_valid_i;
  assign start  = bus.start_i;
  assign mode   = bus.mode_i;

  chan_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (SEED_EFF),
    .step  (accept),
    .state (lfsr_q)
  );

  // A start pulse makes the symbol accepted in the same cycle index 0.
  always_comb begin
    eff_ct     = start ? 16'h0000 : sym_ct_q;
    eff_per    = start ? 8'h00 : per_q;
    eff_active = (eff_ct < WIN);
    ct_next    = eff_ct;
    per_next   = eff_per;
    if (accept) begin
      if (eff_active) ct_next = eff_ct + 16'h0001;
      per_next = (eff_per == PER_LAST) ? 8'h00 : eff_per + 8'h01;
    end
  end

  assign trig      = (lfsr_q[RATE_N-1:1] == '0);
  assign rand_raw  = lfsr_q[15 -: SYM_W];
  assign rand_mask = (rand_raw == '0) ? SYM_W'(1) : rand_raw;

  // Burst FSM: burst_ct counts burst symbols already emitted.
  always_comb begin
    cur_state    = state_q;
    cur_burst_ct = burst_ct_q;
    if (start || mode != MODE_BURST) begin
      cur_state    = ST_CLEAN;
      cur_burst_ct = 8'h00;
    end
    state_d    = cur_state;
    burst_ct_d = cur_burst_ct;
    burst_hit  = 1'b0;
    if (accept && mode == MODE_BURST) begin
      if (!eff_active) begin
        state_d    = ST_CLEAN;
        burst_ct_d = 8'h00;
      end else if (cur_state == ST_BURST) begin
        burst_hit = 1'b1;
        if (cur_burst_ct == BL_LAST) begin
          state_d    = ST_CLEAN;
          burst_ct_d = 8'h00;
        end else begin
          burst_ct_d = cur_burst_ct + 8'h01;
        end
      end else if (trig) begin
        burst_hit = 1'b1;
        if (BURST_LEN > 1) begin
          state_d    = ST_BURST;
          burst_ct_d = 8'h01;
        end
      end
    end
    if (accept && ct_next >= WIN) begin
      state_d    = ST_CLEAN;
      burst_ct_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAN;
      burst_ct_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      burst_ct_q <= burst_ct_d;
    end
  end

  always_comb begin
    mask_d = '0;
    if (eff_active) begin
      unique case (mode)
        MODE_RANDOM:   if (trig) mask_d = rand_mask;
        MODE_BURST:    if (burst_hit) mask_d = rand_mask;
        MODE_PERIODIC: if (eff_per == PER_LAST) mask_d = SYM_W'(1);
        default:       mask_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct_q    <= 16'h0000;
      per_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      err_mask_q  <= '0;
    end else begin
      sym_ct_q    <= ct_next;
      per_q       <= per_next;
      out_valid_q <= accept;
      if (accept) begin
        out_sym_q  <= bus.in_sym_i ^ mask_d;
        err_mask_q <= mask_d;
      end
    end
  end

`ifdef CHAN_ERR_STATS_EN
  logic [15:0] inj_q, bits_q, inj_base, bits_base, inj_d, bits_d;
  logic [16:0] bits_sum;

  always_comb begin
    inj_base  = start ? 16'h0000 : inj_q;
    bits_base = start ? 16'h0000 : bits_q;
    bits_sum  = {1'b0, bits_base} + 17'(popcount8(8'(mask_d)));
    inj_d     = inj_base;
    bits_d    = bits_base;
    if (accept && mask_d != '0) begin
      inj_d  = (inj_base == 16'hFFFF) ? 16'hFFFF : inj_base + 16'h0001;
      bits_d = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_q  <= 16'h0000;
      bits_q <= 16'h0000;
    end else begin
      inj_q  <= inj_d;
      bits_q <= bits_d;
    end
  end

  assign bus.inj_count_o     = inj_q;
  assign bus.bit_err_count_o = bits_q;
`else
  assign bus.inj_count_o     = 16'h0000;
  assign bus.bit_err_count_o = 16'h0000;
`endif

  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_sym_o    = out_sym_q;
  assign bus.err_mask_o   = err_mask_q;
  assign bus.win_active_o = (sym_ct_q < WIN);
  assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_chan_err_injector.sv
// Self-checking bench for chan_err_injector using a behavioural reference model.
module tb_chan_err_injector;
  import chan_err_pkg::*;

  localparam int          SYM_W     = 2;
  localparam int          RATE_N    = 4;
  localparam int          BURST_LEN = 16;
  localparam int          PERIOD    = 16;
  localparam int          WINDOW    = 256;
  localparam logic [15:0] SEED      = 16'hACE1;
`ifdef CHAN_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chan_err_injector_if #(.SYM_W(SYM_W)) bus();

  chan_err_injector #(
    .SYM_W(SYM_W), .RATE_N(RATE_N), .BURST_LEN(BURST_LEN),
    .PERIOD(PERIOD), .WINDOW(WINDOW), .SEED(SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: {expected out_sym, expected mask}
  logic [2*SYM_W-1:0] exp_q[$];

  // reference model state
  logic [15:0]      m_lfsr;
  int               m_ct, m_burst_left, m_inj, m_bits;
  logic [SYM_W-1:0] last_sym, last_mask;
  int               run_len, max_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    n[15] = s[0];
    n[13] = s[14] ^ s[0];
    n[12] = s[13] ^ s[0];
    n[10] = s[11] ^ s[0];
    return n;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_ct = 0; m_burst_left = 0; m_inj = 0; m_bits = 0;
    last_sym = '0; last_mask = '0; run_len = 0; max_run = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit valid, input bit start, input logic [1:0] mode,
                            input logic [SYM_W-1:0] sym);
    logic [SYM_W-1:0] rm, mask;
    bit trig;
    if (start) begin m_ct = 0; m_burst_left = 0; m_inj = 0; m_bits = 0; end
    if (mode != 2'b10) m_burst_left = 0;
    if (!valid) return;
    trig = (int'(m_lfsr) % (1 << RATE_N)) < 2;
    rm = m_lfsr[15:16-SYM_W];
    if (rm == '0) rm = 1;
    mask = '0;
    if (m_ct < WINDOW) begin
      case (mode)
        2'b01: if (trig) mask = rm;
        2'b10: begin
          if (m_burst_left > 0) begin mask = rm; m_burst_left--; end
          else if (trig) begin mask = rm; m_burst_left = BURST_LEN - 1; end
        end
        2'b11: if (m_ct % PERIOD == PERIOD - 1) mask = 1;
        default: mask = '0;
      endcase
    end else begin
      m_burst_left = 0;
    end
    if (mask != '0) begin
      m_inj  = (m_inj + 1 > 65535) ? 65535 : m_inj + 1;
      m_bits = (m_bits + $countones(mask) > 65535) ? 65535 : m_bits + $countones(mask);
    end
    exp_q.push_back({sym ^ mask, mask});
    if (m_ct < WINDOW) m_ct++;
    if (m_ct >= WINDOW) m_burst_left = 0;
    m_lfsr = ref_lfsr(m_lfsr);
  endtask

  // driver: apply one cycle of stimulus, then check outputs #1 after the edge
  task automatic drive(input bit valid, input bit start, input logic [1:0] mode,
                       input logic [SYM_W-1:0] sym);
    logic [2*SYM_W-1:0] e;
    bus.in_valid_i = valid;
    bus.start_i    = start;
    bus.mode_i     = err_mode_e'(mode);
    bus.in_sym_i   = sym;
    model_step(valid, start, mode, sym);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check_val("out_valid", 32'(bus.out_valid_o), 32'(valid));
    if (valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("out_sym", 32'(bus.out_sym_o), 32'(e[2*SYM_W-1:SYM_W]));
        check_val("err_mask", 32'(bus.err_mask_o), 32'(e[SYM_W-1:0]));
        last_sym  = e[2*SYM_W-1:SYM_W];
        last_mask = e[SYM_W-1:0];
      end
      if (bus.err_mask_o != '0) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end else begin
      check_val("hold_sym", 32'(bus.out_sym_o), 32'(last_sym));
      check_val("hold_mask", 32'(bus.err_mask_o), 32'(last_mask));
    end
    check_val("win_active", 32'(bus.win_active_o), 32'(m_ct < WINDOW));
    check_val("inj_count", 32'(bus.inj_count_o), STATS ? 32'(m_inj) : 32'd0);
    check_val("bit_err_count", 32'(bus.bit_err_count_o), STATS ? 32'(m_bits) : 32'd0);
    check_val("fsm_state", 32'(bus.dbg_state_o), 32'(m_burst_left > 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
    check_val({tag, "_sym"}, 32'(bus.out_sym_o), 32'd0);
    check_val({tag, "_mask"}, 32'(bus.err_mask_o), 32'd0);
    check_val({tag, "_win"}, 32'(bus.win_active_o), 32'd1);
    check_val({tag, "_inj"}, 32'(bus.inj_count_o), 32'd0);
    check_val({tag, "_bits"}, 32'(bus.bit_err_count_o), 32'd0);
    check_val({tag, "_state"}, 32'(bus.dbg_state_o), 32'(ST_CLEAN));
  endtask

  task automatic run_until_burst(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      drive(1'b1, 1'b0, 2'b10, SYM_W'($urandom_range(0, (1 << SYM_W) - 1)));
      if (m_burst_left > 4) found = 1'b1;
    end
    check_val({tag, "_burst_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    bit found;
    bus.mode_i = MODE_OFF; bus.start_i = 1'b0; bus.in_valid_i = 1'b0; bus.in_sym_i = '0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // OFF: symbols pass through untouched
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 2'b00, 2'b10);

    // PERIODIC: bit 0 flipped at indices 15, 31, 47, 63
    for (int i = 0; i < 64; i++) drive(1'b1, (i == 0), 2'b11, 2'b00);
    check_val("per_inj_total", 32'(bus.inj_count_o), STATS ? 32'd4 : 32'd0);
    check_val("per_bits_total", 32'(bus.bit_err_count_o), STATS ? 32'd4 : 32'd0);

    // BURST: run lengths bounded, OFF mid-burst silences the mask at once
    drive(1'b1, 1'b1, 2'b10, 2'b01);
    max_run = 0; run_len = 0;
    for (int i = 0; i < 150; i++) drive(1'b1, 1'b0, 2'b10, SYM_W'($urandom_range(0, 3)));
    run_until_burst("off", found);
    drive(1'b1, 1'b0, 2'b00, 2'b11);
    check_val("off_mid_burst_mask", 32'(bus.err_mask_o), 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 2'b10, SYM_W'($urandom_range(0, 3)));
    check_val("burst_run_le_len", 32'(max_run <= BURST_LEN), 32'd1);

    // RANDOM: window closes after symbol 255, start reopens it
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, (i == 0), 2'b01, SYM_W'($urandom_range(0, 3)));
      if (i == 254) check_val("win_open_254", 32'(bus.win_active_o), 32'd1);
      if (i == 255) check_val("win_closed_255", 32'(bus.win_active_o), 32'd0);
    end
    drive(1'b0, 1'b1, 2'b01, 2'b00);
    check_val("restart_win", 32'(bus.win_active_o), 32'd1);
    check_val("restart_inj", 32'(bus.inj_count_o), 32'd0);
    check_val("restart_bits", 32'(bus.bit_err_count_o), 32'd0);

    // valid toggling: LFSR advances only on accepted symbols
    for (int i = 0; i < 120; i++) drive((i % 2) == 0, 1'b0, 2'b01, SYM_W'($urandom_range(0, 3)));

    // reset mid-burst: immediate clear, LFSR restarts from SEED
    drive(1'b1, 1'b1, 2'b10, 2'b00);
    run_until_burst("rst", found);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("rst_held");
    rst = 1'b1;
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 2'b01, SYM_W'($urandom_range(0, 3)));
    drive(1'b1, 1'b0, 2'b10, 2'b00);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 2'b10, SYM_W'($urandom_range(0, 3)));
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
